e_mdu: RTL and testbench
========================

Name: e_mdu

Overview:
- E-stage multiply/divide unit with its own sequencer, built alongside the E-stage ALU in the five-stage MIPS pipeline.
- Owns the HI/LO registers and executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Runs a multi-cycle busy sequence that the hazard unit reads to stall D-stage MDU instructions.
- Results are computed combinationally at start, held in shadow registers, and committed to HI/LO when the latency counter expires.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- MDUOp  input  4  operation select; encodings in def.v.
- Start  input  1  E-stage instruction valid; qualifies MDUOp.
- A  input  32  rs operand (forwarded).
- B  input  32  rt operand (forwarded).
- Busy  output  1  registered; high while a mult/div sequence is in flight.
- HI  output  32  HI register value.
- LO  output  32  LO register value.
- MDUOut  output  32  mfhi gives HI, mflo gives LO, otherwise 0; combinational from the registers.

Behaviour:
- Clock and reset:
  - One clock, clk. reset is synchronous and active-high.
  - Reset effect: state=IDLE, Busy=0, count=0, HI=0, LO=0, shadow registers=0.
  - reset wins over every other input in the same cycle.
  - reset asserted mid-sequence aborts the operation; no commit occurs.
- Op encodings (def.v):
  - NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4
  - MFHI=5, MFLO=6, MTHI=7, MTLO=8
  - codes 9-15 are treated as NONE.
- FSM states: IDLE, RUN.
- IDLE, when Start=1 and MDUOp is MULT/MULTU/DIV/DIVU at edge N:
  - Latch the 64-bit result into hi_n/lo_n.
  - Load count with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; Busy=1 from edge N.
- RUN, each edge:
  - count decrements.
  - At the edge where count==1: HI<=hi_n, LO<=lo_n, Busy<=0, go to IDLE.
  - Result: Busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles, and HI/LO change on the same edge Busy falls.
- Arithmetic:
  - MULT: signed 32x32 to 64; HI = product[63:32], LO = product[31:0].
  - MULTU: same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (B==0): full DIV_CYCLES busy sequence still runs; HI/LO keep their previous values (no commit).
- MTHI/MTLO with Start=1 in IDLE: HI<=A or LO<=A at the next edge; Busy stays 0.
- MFHI/MFLO: pure reads, no state change.
- Start=1 with any MDU op while in RUN:
  - Ignored.
  - The hazard unit must stall using (Start & isMDU) | Busy; the bench checks that this condition is never violated silently.
- Back-to-back: a new start is accepted in the first cycle Busy=0, i.e. the edge after commit.
- Start=0: MDUOp is ignored entirely.

Decomposition:
- def.v gets the `MDU_* op macros (NONE..MTLO) beside the existing `ALU_* macros.
- The hazard unit and controller include the same header.
- Internals stay in one module: 2-state FSM, 4-bit counter, signed/unsigned multiply and divide datapath, shadow registers.
- No sub-module is needed. If synthesis timing later forces an iterative divider, split it out as e_mdu_div.

Test Plan:
- Reset, then idle: HI=0, LO=0, Busy=0, MDUOut=0 on the first cycle after reset deasserts.
- MULT with A=0xFFFFFFFD (-3), B=5:
  - Busy high for exactly 5 cycles.
  - HI=0xFFFFFFFF and LO=0xFFFFFFF1 appear on the edge Busy falls; not earlier.
- MULTU with A=0xFFFFFFFF, B=2: HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
- DIV with A=0xFFFFFFF9 (-7), B=2:
  - Busy high 10 cycles.
  - Result LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Follow with DIVU 7/0: Busy high 10 cycles and HI/LO unchanged.
- Start MULT, then in cycle 3 of RUN apply Start+MTHI A=0x1234 and assert reset in cycle 4:
  - The MTHI has no effect.
  - After reset: HI=0, LO=0, Busy=0, with no late commit.
- MTLO A=0xCAFEBABE then MFLO in the next cycle: MDUOut=0xCAFEBABE and Busy=0 throughout. Then issue MULT on the first cycle after a prior commit; it is accepted immediately.

Source files
------------

// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - MDU op encodings, FSM states and shared constants for e_mdu
package e_mdu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit owning HI/LO with a fixed-latency busy sequencer
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      MDUOp,
    input  logic            Start,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            Busy,
    output logic [XLEN-1:0] HI,
    output logic [XLEN-1:0] LO,
    output logic [XLEN-1:0] MDUOut
);

    mdu_state_e      state_q, state_d;
    logic [3:0]      count_q, count_d;
    logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0] hi_n_q, hi_n_d, lo_n_q, lo_n_d;
    logic            commit_q, commit_d;

    logic signed [63:0]     smul;
    logic [63:0]            umul;
    logic [XLEN-1:0]        b_safe;
    logic signed [XLEN-1:0] squot, srem;
    logic [XLEN-1:0]        uquot, urem;
    logic [XLEN-1:0]        res_hi, res_lo;
    logic                   b_zero;

    assign smul   = $signed({{XLEN{A[XLEN-1]}}, A}) * $signed({{XLEN{B[XLEN-1]}}, B});
    assign umul   = {{XLEN{1'b0}}, A} * {{XLEN{1'b0}}, B};
    assign b_zero = (B == '0);
    // Divisor forced non-zero so the divider never yields X; the result is discarded anyway.
    assign b_safe = b_zero ? {{(XLEN-1){1'b0}}, 1'b1} : B;
    assign squot  = $signed(A) / $signed(b_safe);
    assign srem   = $signed(A) % $signed(b_safe);
    assign uquot  = A / b_safe;
    assign urem   = A % b_safe;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (MDUOp)
            MDU_MULT:  begin res_hi = smul[63:32]; res_lo = smul[31:0]; end
            MDU_MULTU: begin res_hi = umul[63:32]; res_lo = umul[31:0]; end
            MDU_DIV:   begin res_hi = srem;        res_lo = squot;      end
            MDU_DIVU:  begin res_hi = urem;        res_lo = uquot;      end
            default:   ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_n_d   = hi_n_q;
        lo_n_d   = lo_n_q;
        commit_d = commit_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    if (is_long_op(MDUOp)) begin
                        hi_n_d  = res_hi;
                        lo_n_d  = res_lo;
                        state_d = S_RUN;
                        if (MDUOp == MDU_DIV || MDUOp == MDU_DIVU) begin
                            count_d  = 4'(DIV_CYCLES);
                            commit_d = !b_zero;
                        end else begin
                            count_d  = 4'(MULT_CYCLES);
                            commit_d = 1'b1;
                        end
                    end else if (MDUOp == MDU_MTHI) begin
                        hi_d = A;
                    end else if (MDUOp == MDU_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            S_RUN: begin
                count_d = count_q - 4'd1;
                if (count_q <= 4'd1) begin
                    state_d = S_IDLE;
                    if (commit_q) begin
                        hi_d = hi_n_q;
                        lo_d = lo_n_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_n_q   <= '0;
            lo_n_q   <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_n_q   <= hi_n_d;
            lo_n_q   <= lo_n_d;
            commit_q <= commit_d;
        end
    end

    assign Busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

    always_comb begin
        MDUOut = '0;
        if (Start && MDUOp == MDU_MFHI) MDUOut = hi_q;
        if (Start && MDUOp == MDU_MFLO) MDUOut = lo_q;
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - self-checking bench for e_mdu: vector table plus abort/forwarding/back-to-back sequences
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  MDUOp = 4'd0;
    logic        Start = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Busy;
    logic [31:0] HI, LO, MDUOut;

    int tests = 0;
    int fails = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .MDUOp  (MDUOp),
        .Start  (Start),
        .A      (A),
        .B      (B),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO),
        .MDUOut (MDUOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    vec_t vecs[14];

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDUOp = op;
        A = a;
        B = b;
        @(posedge clk);
        #1;
        Start = 1'b0;
        MDUOp = 4'd0;
    endtask

    // Issues one op, counts Busy cycles, requires HI/LO frozen until Busy falls, then checks result.
    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] hi0, lo0;
        int n;
        int early;
        hi0 = HI;
        lo0 = LO;
        n = 0;
        early = 0;
        drive(v.op, v.a, v.b);
        @(negedge clk);
        while (Busy && n < 40) begin
            if (HI !== hi0 || LO !== lo0) early++;
            n++;
            @(negedge clk);
        end
        check32($sformatf("vec%0d busy_cycles", idx), 32'(n), 32'(v.cyc));
        check32($sformatf("vec%0d early_commit", idx), 32'(early), 32'd0);
        check32($sformatf("vec%0d HI", idx), HI, v.exp_hi);
        check32($sformatf("vec%0d LO", idx), LO, v.exp_lo);
    endtask

    initial begin
        vecs[0]  = '{4'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
        vecs[1]  = '{4'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
        vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[3]  = '{4'd4, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4]  = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
        vecs[5]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[6]  = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        vecs[7]  = '{4'd3, 32'd0,        32'd0,        32'h40000000, 32'h00000000, 10};
        vecs[8]  = '{4'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
        vecs[9]  = '{4'd9, 32'h11111111, 32'h22222222, 32'h00000001, 32'h00000000, 0};
        vecs[10] = '{4'd5, 32'h33333333, 32'h44444444, 32'h00000001, 32'h00000000, 0};
        vecs[11] = '{4'd7, 32'hABCD0000, 32'd0,        32'hABCD0000, 32'h00000000, 0};
        vecs[12] = '{4'd8, 32'h13579BDF, 32'd0,        32'hABCD0000, 32'h13579BDF, 0};
        vecs[13] = '{4'd1, 32'd6,        32'd7,        32'h00000000, 32'h0000002A, 5};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check32("reset HI", HI, 32'h0);
        check32("reset LO", LO, 32'h0);
        check32("reset Busy", 32'(Busy), 32'h0);
        check32("reset MDUOut", MDUOut, 32'h0);

        // Each entry is issued on the first Busy=0 cycle after the previous one.
        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Start of another op while RUN must be ignored.
        drive(4'd1, 32'd3, 32'd3);
        drive(4'd4, 32'd100, 32'd7);
        begin
            int n;
            n = 1;
            @(negedge clk);
            while (Busy && n < 40) begin n++; @(negedge clk); end
            check32("run_ignore busy_cycles", 32'(n), 32'd5);
            check32("run_ignore HI", HI, 32'h0);
            check32("run_ignore LO", LO, 32'h9);
        end

        // Put known non-zero values in HI/LO before the abort test.
        drive(4'd7, 32'hABCD0000, 32'd0);
        drive(4'd8, 32'h13579BDF, 32'd0);
        @(negedge clk);

        // MTHI during RUN cycle 3 ignored, reset in cycle 4 aborts without commit.
        drive(4'd1, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        Start = 1'b1; MDUOp = 4'd7; A = 32'h1234;
        @(posedge clk);
        #1;
        Start = 1'b0; MDUOp = 4'd0; reset = 1'b1;
        @(negedge clk);
        check32("abort mthi_ignored HI", HI, 32'hABCD0000);
        check32("abort still_busy", 32'(Busy), 32'h1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check32("abort HI", HI, 32'h0);
        check32("abort LO", LO, 32'h0);
        check32("abort Busy", 32'(Busy), 32'h0);
        repeat (12) @(negedge clk);
        check32("abort late_commit HI", HI, 32'h0);
        check32("abort late_commit LO", LO, 32'h0);

        // MTLO then MFLO forwarding, and Start=0 gating of the read mux.
        drive(4'd8, 32'hCAFEBABE, 32'd0);
        Start = 1'b1; MDUOp = 4'd6;
        @(negedge clk);
        check32("mflo MDUOut", MDUOut, 32'hCAFEBABE);
        check32("mflo Busy", 32'(Busy), 32'h0);
        MDUOp = 4'd5;
        #1;
        check32("mfhi MDUOut", MDUOut, 32'h0);
        Start = 1'b0; MDUOp = 4'd6;
        #1;
        check32("mflo nostart MDUOut", MDUOut, 32'h0);
        @(posedge clk);
        #1;
        check32("mflo no_state_change LO", LO, 32'hCAFEBABE);
        MDUOp = 4'd0;

        // Back-to-back: second MULT issued on the first cycle after the commit.
        run_vec(100, '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 5});
        run_vec(101, '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 5});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
